// File: rtl/gemm_ctrl_pkg.sv
// Shared types and default sizes for the GEMM batch sequencer.
// Holds the controller state enum and the default buffer geometry.
// Also provides the counter-width helper used for address ports.
package gemm_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRM   = 3'd1,
    ST_LOAD  = 3'd2,
    ST_COMP  = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  localparam int DEF_SRC_DEPTH = 32;
  localparam int DEF_DST_DEPTH = 16;
  localparam int DEF_PRM_BANKS = 4;
  localparam int DEF_PRM_DEPTH = 8;

  // Width of a counter spanning n values; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/loop1.sv
// Wrap counter: counts enabled events 0..MAX and wraps back to 0.
// Latency: count updates the cycle after i_en; o_wrap is combinational.
// No backpressure; i_clr has priority over i_en.
module loop1 #(
  parameter int W   = 4,
  parameter int MAX = 15
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_cnt,
  output logic         o_wrap
);

  logic [W-1:0] r_cnt;
  logic         w_at_max;

  assign w_at_max = (r_cnt == W'(MAX));
  assign o_wrap   = i_en & w_at_max;
  assign o_cnt    = r_cnt;

  // Advance on enable, fold back to zero after the terminal value.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_at_max ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/gemm_batch_ctrl.sv
// GEMM batch sequencer: parameter load, source fill, compute handshake, destination drain.
// Latency: write strobes are combinational with the accepted beat; destination data is 1 cycle after dst_v.
// Backpressure: src_valid/src_ready per beat; dst_ready stalls further reads so the buffer output holds.
module gemm_batch_ctrl
  import gemm_ctrl_pkg::*;
#(
  parameter  int SRC_DEPTH = DEF_SRC_DEPTH,
  parameter  int DST_DEPTH = DEF_DST_DEPTH,
  parameter  int PRM_BANKS = DEF_PRM_BANKS,
  parameter  int PRM_DEPTH = DEF_PRM_DEPTH,
  localparam int SAW       = cnt_w(SRC_DEPTH),
  localparam int DAW       = cnt_w(DST_DEPTH),
  localparam int PAW       = cnt_w(PRM_DEPTH),
  localparam int BKW       = cnt_w(PRM_BANKS)
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_matw,
  input  logic                 i_run,
  input  logic                 i_src_valid,
  output logic                 o_src_ready,
  output logic                 o_src_v,
  output logic [SAW-1:0]       o_src_a,
  output logic [PRM_BANKS-1:0] o_prm_v,
  output logic [PAW-1:0]       o_prm_a,
  output logic                 o_prm_done,
  output logic                 o_s_init,
  input  logic                 i_s_fin,
  output logic                 o_dst_v,
  output logic [DAW-1:0]       o_dst_a,
  output logic                 o_dst_valid,
  input  logic                 i_dst_ready,
  output logic                 o_dst_last,
  output logic                 o_busy
);

  state_t         r_state;
  state_t         w_next;

  logic [SAW-1:0] w_sa;
  logic           w_sa_wrap;
  logic [PAW-1:0] w_pw;
  logic           w_pw_wrap;
  logic [BKW-1:0] w_pb;
  logic           w_pb_wrap;
  logic [DAW-1:0] w_da;
  logic           w_da_wrap;

  logic           r_da_done;
  logic           r_dst_valid;
  logic           r_dst_last;

  logic           w_prm_beat;
  logic           w_src_beat;
  logic           w_rd_en;
  logic           w_issue;
  logic           w_last_acc;
  logic           w_clr;

  // A parameter beat only counts while the host still requests write mode,
  // and a source beat only while the batch is still enabled, so an abort
  // cycle never writes a buffer or fires a pulse.
  assign w_prm_beat = (r_state == ST_PRM) & i_matw & i_src_valid;
  assign w_src_beat = (r_state == ST_LOAD) & i_run & i_src_valid;

  // The read pipeline advances when its output slot is empty or being taken.
  assign w_rd_en    = ~r_dst_valid | i_dst_ready;
  assign w_issue    = (r_state == ST_DRAIN) & i_run & ~r_da_done & w_rd_en;
  assign w_last_acc = (r_state == ST_DRAIN) & r_dst_valid & r_dst_last & i_dst_ready;

  // Every return to IDLE and every completed drain starts the next batch from zero.
  assign w_clr      = (w_next == ST_IDLE) | w_last_acc;

  loop1 #(.W(SAW), .MAX(SRC_DEPTH - 1)) u_sa (
    .i_clk(i_clk), .i_reset(i_reset), .i_clr(w_clr), .i_en(w_src_beat),
    .o_cnt(w_sa), .o_wrap(w_sa_wrap)
  );

  loop1 #(.W(PAW), .MAX(PRM_DEPTH - 1)) u_pw (
    .i_clk(i_clk), .i_reset(i_reset), .i_clr(w_clr), .i_en(w_prm_beat),
    .o_cnt(w_pw), .o_wrap(w_pw_wrap)
  );

  loop1 #(.W(BKW), .MAX(PRM_BANKS - 1)) u_pb (
    .i_clk(i_clk), .i_reset(i_reset), .i_clr(w_clr), .i_en(w_prm_beat & w_pw_wrap),
    .o_cnt(w_pb), .o_wrap(w_pb_wrap)
  );

  loop1 #(.W(DAW), .MAX(DST_DEPTH - 1)) u_da (
    .i_clk(i_clk), .i_reset(i_reset), .i_clr(w_clr), .i_en(w_issue),
    .o_cnt(w_da), .o_wrap(w_da_wrap)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state selection and state-qualified outputs.
  always_comb begin
    w_next      = r_state;
    o_src_ready = 1'b0;
    o_busy      = 1'b1;
    case (r_state)
      ST_IDLE: begin
        o_busy = 1'b0;
        if (i_matw) begin
          w_next = ST_PRM;
        end else if (i_run) begin
          w_next = ST_LOAD;
        end
      end
      ST_PRM: begin
        o_src_ready = 1'b1;
        if (!i_matw) begin
          w_next = ST_IDLE;
        end else if (w_prm_beat && w_pw_wrap && w_pb_wrap) begin
          w_next = ST_IDLE;
        end
      end
      ST_LOAD: begin
        o_src_ready = 1'b1;
        if (!i_run) begin
          w_next = ST_IDLE;
        end else if (w_src_beat && w_sa_wrap) begin
          w_next = ST_COMP;
        end
      end
      ST_COMP: begin
        if (!i_run) begin
          w_next = ST_IDLE;
        end else if (i_s_fin) begin
          w_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!i_run) begin
          w_next = ST_IDLE;
        end else if (w_last_acc) begin
          w_next = ST_LOAD;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Remember that the final read of the batch has been issued.
  always_ff @(posedge i_clk) begin
    if (i_reset || w_clr) begin
      r_da_done <= 1'b0;
    end else if (w_da_wrap) begin
      r_da_done <= 1'b1;
    end
  end

  // Output stage of the destination read pipeline; holds while the host stalls.
  always_ff @(posedge i_clk) begin
    if (i_reset || w_clr) begin
      r_dst_valid <= 1'b0;
      r_dst_last  <= 1'b0;
    end else if (w_rd_en) begin
      r_dst_valid <= w_issue;
      r_dst_last  <= w_da_wrap;
    end
  end

  assign o_src_v     = w_src_beat;
  assign o_src_a     = w_sa;
  assign o_s_init    = w_src_beat & w_sa_wrap;
  assign o_prm_v     = w_prm_beat ? (PRM_BANKS'(1) << w_pb) : '0;
  assign o_prm_a     = w_pw;
  assign o_prm_done  = w_prm_beat & w_pw_wrap & w_pb_wrap;
  assign o_dst_v     = w_issue;
  assign o_dst_a     = w_da;
  assign o_dst_valid = r_dst_valid;
  assign o_dst_last  = r_dst_last;

endmodule

// File: tb/tb_gemm_batch_ctrl.sv
// Testbench for gemm_batch_ctrl: default geometry instance plus a small-geometry instance.
module tb_gemm_batch_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-geometry DUT
  logic       reset, matw, run, src_valid, s_fin, dst_ready;
  logic       src_ready, src_v, prm_done, s_init, dst_v, dst_valid, dst_last, busy;
  logic [4:0] src_a;
  logic [3:0] prm_v;
  logic [2:0] prm_a;
  logic [3:0] dst_a;

  // Small-geometry DUT (8/4/2/4)
  logic       sm_matw, sm_run, sm_src_valid, sm_s_fin, sm_dst_ready;
  logic       sm_src_ready, sm_src_v, sm_prm_done, sm_s_init, sm_dst_v, sm_dst_valid, sm_dst_last, sm_busy;
  logic [2:0] sm_src_a;
  logic [1:0] sm_prm_v;
  logic [1:0] sm_prm_a;
  logic [1:0] sm_dst_a;

  gemm_batch_ctrl u_dut (
    .i_clk(clk), .i_reset(reset), .i_matw(matw), .i_run(run), .i_src_valid(src_valid),
    .o_src_ready(src_ready), .o_src_v(src_v), .o_src_a(src_a),
    .o_prm_v(prm_v), .o_prm_a(prm_a), .o_prm_done(prm_done), .o_s_init(s_init),
    .i_s_fin(s_fin), .o_dst_v(dst_v), .o_dst_a(dst_a), .o_dst_valid(dst_valid),
    .i_dst_ready(dst_ready), .o_dst_last(dst_last), .o_busy(busy)
  );

  gemm_batch_ctrl #(.SRC_DEPTH(8), .DST_DEPTH(4), .PRM_BANKS(2), .PRM_DEPTH(4)) u_small (
    .i_clk(clk), .i_reset(reset), .i_matw(sm_matw), .i_run(sm_run), .i_src_valid(sm_src_valid),
    .o_src_ready(sm_src_ready), .o_src_v(sm_src_v), .o_src_a(sm_src_a),
    .o_prm_v(sm_prm_v), .o_prm_a(sm_prm_a), .o_prm_done(sm_prm_done), .o_s_init(sm_s_init),
    .i_s_fin(sm_s_fin), .o_dst_v(sm_dst_v), .o_dst_a(sm_dst_a), .o_dst_valid(sm_dst_valid),
    .i_dst_ready(sm_dst_ready), .o_dst_last(sm_dst_last), .o_busy(sm_busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // Scoreboards: expectations pushed by the stimulus, popped when the DUT acts.
  int q_prm[$];
  int q_src[$];
  int q_dst[$];

  // Destination buffer model: registered read, data equals the read address.
  logic [3:0] mem_q = '0;
  always @(posedge clk) if (dst_v) mem_q <= dst_a;

  always @(negedge clk) begin
    if (!reset) begin
      if (prm_v != 4'd0) begin
        if (q_prm.size() == 0) chk("prm_unexpected", 32'(prm_v), 0);
        else chk("prm_beat", 32'({prm_done, prm_v, prm_a}), q_prm.pop_front());
      end else if (prm_done) chk("prm_done_alone", 1, 0);
      if (src_v) begin
        if (q_src.size() == 0) chk("src_unexpected", 32'(src_a), 32'hFFFF);
        else chk("src_beat", 32'({s_init, src_a}), q_src.pop_front());
      end else if (s_init) chk("s_init_alone", 1, 0);
      if (dst_valid && dst_ready) begin
        if (q_dst.size() == 0) chk("dst_unexpected", 32'(mem_q), 32'hFFFF);
        else chk("dst_beat", 32'({dst_last, mem_q}), q_dst.pop_front());
      end
      if (dst_valid && !dst_ready && dst_v) chk("dst_v_in_stall", 1, 0);
    end
  end

  typedef struct {
    logic       matw, run, sv, sfin, drdy;
    logic [5:0] exp;   // {src_ready, busy, src_v, s_init, dst_v, dst_valid}
  } vec_t;
  vec_t tbl[10];

  task automatic push_src(input int n);
    for (int i = 0; i < n; i++) q_src.push_back(((i == n - 1 && n == 32) ? 32 : 0) | i);
  endtask

  task automatic stream_src(input int n);
    push_src(n);
    src_valid = 1'b1;
    for (int i = 0; i < n; i++) adv();
    src_valid = 1'b0;
  endtask

  int cnt, acc, done_at, last_at, nb;
  logic prev_stall;
  logic [3:0] prev_mem;

  initial begin
    reset = 1'b1; matw = 0; run = 0; src_valid = 0; s_fin = 0; dst_ready = 0;
    sm_matw = 0; sm_run = 0; sm_src_valid = 0; sm_s_fin = 0; sm_dst_ready = 0;
    adv(); adv();
    reset = 1'b0;

    // Control vectors: reset state, priority, aborts, stray s_fin.
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'b000000};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'b110000};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'b110000};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'b000000};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 6'b110000};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'b110000};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'b000000};
    tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'b000000};
    for (int i = 0; i < 10; i++) begin
      matw = tbl[i].matw; run = tbl[i].run; src_valid = tbl[i].sv;
      s_fin = tbl[i].sfin; dst_ready = tbl[i].drdy;
      @(negedge clk);
      chk($sformatf("vec%0d", i), 32'({src_ready, busy, src_v, s_init, dst_v, dst_valid}), 32'(tbl[i].exp));
      adv();
    end
    matw = 0; run = 0; s_fin = 0; dst_ready = 0; src_valid = 0;

    // Parameter load: 4 banks x 8 words, done on beat 32.
    matw = 1; adv();
    for (int i = 0; i < 32; i++) begin
      q_prm.push_back(((i == 31) ? 128 : 0) | ((1 << (i / 8)) << 3) | (i % 8));
      src_valid = 1; adv();
    end
    src_valid = 0; matw = 0;
    @(negedge clk); chk("prm_end_idle", 32'(busy), 0); chk("prm_q_empty", q_prm.size(), 0);
    adv();

    // Reset during parameter load, then abort via matw=0 clears the word counter.
    matw = 1; adv();
    for (int i = 0; i < 5; i++) begin q_prm.push_back(8 | i); src_valid = 1; adv(); end
    src_valid = 0; reset = 1; adv();
    reset = 0; matw = 0;
    @(negedge clk); chk("reset_busy", 32'(busy), 0); chk("reset_src_ready", 32'(src_ready), 0);
    adv();
    matw = 1; adv();
    for (int i = 0; i < 3; i++) begin q_prm.push_back(8 | i); src_valid = 1; adv(); end
    src_valid = 0; matw = 0; adv();
    @(negedge clk); chk("prm_abort_idle", 32'(busy), 0);
    adv();
    matw = 1; adv();
    q_prm.push_back(8); src_valid = 1; adv();
    src_valid = 0; matw = 0; adv();
    chk("prm_q_empty2", q_prm.size(), 0);

    // Source load with gaps: src_a only on valid beats, s_init on beat 32.
    run = 1; adv();
    nb = 0; cnt = 0;
    while (nb < 32 && cnt < 500) begin
      src_valid = (cnt % 3 != 2);
      if (src_valid) begin q_src.push_back(((nb == 31) ? 32 : 0) | nb); nb++; end
      adv(); cnt++;
    end
    chk("load_beats", nb, 32);
    src_valid = 1;   // offered but must not be taken in COMP
    @(negedge clk); chk("comp_src_ready", 32'(src_ready), 0); chk("comp_busy", 32'(busy), 1);
    adv(); src_valid = 0;
    chk("src_q_empty", q_src.size(), 0);

    // Drain with dst_ready high: 16 beats, last accepted 17 cycles after s_fin.
    for (int i = 0; i < 16; i++) q_dst.push_back(((i == 15) ? 16 : 0) | i);
    s_fin = 1; dst_ready = 1; adv(); s_fin = 0;
    cnt = 1;
    while (cnt < 100) begin
      @(negedge clk);
      if (dst_valid && dst_ready && dst_last) break;
      adv(); cnt++;
    end
    chk("drain_cycles", cnt, 17);
    adv();
    @(negedge clk); chk("back_to_load", 32'({src_ready, busy}), 3); chk("dst_q_empty", q_dst.size(), 0);
    adv();

    // Second batch, drain with dst_ready toggling 1010...
    stream_src(32);
    for (int i = 0; i < 16; i++) q_dst.push_back(((i == 15) ? 16 : 0) | i);
    s_fin = 1; dst_ready = 0; adv(); s_fin = 0;
    cnt = 1; acc = 0; prev_stall = 0; prev_mem = '0;
    while (cnt < 200) begin
      dst_ready = (cnt % 2 == 0);
      @(negedge clk);
      if (prev_stall) begin
        chk("stall_hold_valid", 32'(dst_valid), 1);
        chk("stall_hold_data", 32'(mem_q), 32'(prev_mem));
      end
      prev_stall = dst_valid && !dst_ready;
      prev_mem   = mem_q;
      if (dst_valid && dst_ready) begin acc++; if (dst_last) break; end
      adv(); cnt++;
    end
    chk("toggle_accepts", acc, 16);
    dst_ready = 1; adv();

    // run dropped after 10 beats, then a full restart from address 0.
    for (int i = 0; i < 10; i++) q_src.push_back(i);
    src_valid = 1;
    for (int i = 0; i < 10; i++) adv();
    src_valid = 0; run = 0; adv();
    @(negedge clk); chk("run_drop_idle", 32'({src_ready, busy}), 0);
    adv();
    run = 1; adv();
    stream_src(32);
    chk("restart_q_empty", q_src.size(), 0);

    // run dropped mid-drain while stalled clears dst_valid.
    s_fin = 1; dst_ready = 0; adv(); s_fin = 0;
    adv(); adv();
    @(negedge clk); chk("drain_stalled_valid", 32'(dst_valid), 1);
    adv();
    run = 0; adv();
    @(negedge clk); chk("drain_abort", 32'({dst_valid, dst_last, busy}), 0);
    adv();

    // Small geometry: prm_done after 8 beats, s_init after 8, 4 dst beats.
    sm_matw = 1; adv();
    done_at = -1;
    for (int i = 0; i < 8; i++) begin
      sm_src_valid = 1;
      @(negedge clk);
      if (sm_prm_done) done_at = i;
      if (i == 7) chk("sm_last_prm", 32'({sm_prm_v, sm_prm_a}), 32'({2'b10, 2'd3}));
      adv();
    end
    chk("sm_prm_done_at", done_at, 7);
    sm_matw = 0; sm_src_valid = 0;
    @(negedge clk); chk("sm_prm_idle", 32'(sm_busy), 0);
    adv();
    sm_run = 1; adv();
    done_at = -1;
    for (int i = 0; i < 8; i++) begin
      sm_src_valid = 1;
      @(negedge clk);
      if (sm_s_init) done_at = i;
      if (i == 0 || i == 7) chk("sm_src_a", 32'({sm_src_v, sm_src_ready, sm_src_a}), 32'(24 + i));
      adv();
    end
    chk("sm_s_init_at", done_at, 7);
    sm_src_valid = 0;
    sm_s_fin = 1; sm_dst_ready = 1; adv(); sm_s_fin = 0;
    acc = 0; last_at = -1; cnt = 0;
    while (cnt < 50) begin
      @(negedge clk);
      if (sm_dst_valid && sm_dst_ready) begin
        if (sm_dst_last) last_at = acc;
        acc++;
      end
      if (cnt == 3) chk("sm_dst_a3", 32'({sm_dst_v, sm_dst_a}), 32'({1'b1, 2'd3}));
      adv(); cnt++;
      if (last_at >= 0) break;
    end
    chk("sm_dst_beats", acc, 4);
    chk("sm_dst_last_at", last_at, 3);
    sm_run = 0; adv();
    @(negedge clk); chk("sm_idle", 32'(sm_busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule

// File: doc/gemm_batch_ctrl.md
Name: gemm_batch_ctrl

Overview:
- Parametrised batch sequencer for the GEMM core, replacing the fixed 32/16/4x8 batch controller.
- Sequences parameter loading, source streaming, core compute handshake and destination drain with an explicit state machine.
- Supports real src/dst backpressure through a 1-cycle-latency destination read pipeline that stalls on dst_ready.
- Sits between the DPI-C host stream interface and the core's src/param/dst buffers.

Parameters:
SRC_DEPTH, 32, source words per batch (>=2)
DST_DEPTH, 16, destination words per batch (>=2)
PRM_BANKS, 4, parameter banks; prm_v is one-hot over these
PRM_DEPTH, 8, words per parameter bank (>=2)
SAW/DAW/PAW, derived $clog2 of SRC_DEPTH/DST_DEPTH/PRM_DEPTH, address widths

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
matw  in  1  parameter-write mode request
run  in  1  batch mode enable; low = synchronous abort
src_valid  in  1  host source beat valid
src_ready  out  1  accepting source/parameter beats
src_v  out  1  source buffer write enable
src_a  out  SAW  source buffer address
prm_v  out  PRM_BANKS  one-hot parameter bank write enable
prm_a  out  PAW  parameter word address
prm_done  out  1  1-cycle pulse on the last parameter beat
s_init  out  1  1-cycle pulse: source buffer full, core may start
s_fin  in  1  core finished batch (1-cycle pulse)
dst_v  out  1  destination buffer read enable
dst_a  out  DAW  destination buffer read address
dst_valid  out  1  host destination beat valid (data = buffer output)
dst_ready  in  1  host accepts destination beat
dst_last  out  1  qualifies final destination beat of the batch
busy  out  1  state != IDLE

Behaviour:
- Reset: state IDLE, all counters 0; src_ready, src_v, prm_v, prm_done, s_init, dst_v, dst_valid, dst_last, busy = 0; addresses 0.
- States (shared enum): IDLE, PRM, LOAD, COMP, DRAIN.
- IDLE: matw=1 -> PRM (matw has priority over run); else run=1 -> LOAD.
- PRM: src_ready=1. Beat = src_valid. Each beat: prm_v = 1<<bank, prm_a = word; word increments, wraps at PRM_DEPTH-1 and bank increments. Last beat (bank=PRM_BANKS-1, word=PRM_DEPTH-1): prm_done=1 same cycle, -> IDLE. matw=0 -> IDLE, counters cleared, no pulse.
- LOAD: src_ready=1 only here and in PRM; beat = src_valid&src_ready; src_v=beat combinationally, src_a = sa. sa wraps at SRC_DEPTH-1; that beat asserts s_init combinationally, -> COMP.
- COMP: src_ready=0; waits for s_fin -> DRAIN. s_fin outside COMP is ignored.
- DRAIN: issue read when da_cnt<DST_DEPTH and (!dst_valid | dst_ready): dst_v=1, dst_a=da_cnt, da_cnt++. dst_valid registers dst_v when (!dst_valid | dst_ready); otherwise holds. dst_last registers (dst_v & dst_a==DST_DEPTH-1) under the same enable. Accept of beat with dst_last -> LOAD if run else IDLE; all counters cleared. Buffer output must not change while dst_valid&!dst_ready (guaranteed: no dst_v issued).
- Throughput: 1 beat/cycle in PRM, LOAD and DRAIN with ready held high; DRAIN takes DST_DEPTH+1 cycles minimum.
- run=0 in LOAD/COMP/DRAIN: next cycle IDLE, counters and dst_valid/dst_last cleared, no pulses. run=0 does not affect PRM.
- reset mid-operation identical to reset at power-up.

Decomposition:
- gemm_ctrl_pkg: state enum type, default depth constants.
- Sub-module: reuse shared wrap counter loop1 for sa, prm word, prm bank, da counters; no new sub-module.

Test Plan:
- matw=1, 32 src_valid beats -> prm_v 0001 for words 0..7, then 0010/0100/1000; prm_done on beat 32; state IDLE.
- run=1, 32 beats with src_valid gaps -> src_a 0..31 only on valid beats; s_init on beat 32; src_ready=0 afterwards.
- s_fin, dst_ready=1 -> dst_a 0..15 on consecutive cycles, dst_valid 1 cycle later, dst_last with 16th beat; return to LOAD.
- dst_ready toggled 1010.. -> no dst_v while stalled, dst_valid held, exactly 16 beats accepted in order.
- run dropped after 10 source beats -> IDLE next cycle; new run restarts src_a at 0, s_init after 32 further beats.
- SRC_DEPTH=8, DST_DEPTH=4, PRM_BANKS=2, PRM_DEPTH=4 -> s_init after 8 beats, 4 dst beats, prm_done after 8 beats.
